siso_phase_ctrl: RTL and testbench
==================================

// Module: siso_phase_ctrl
// PURPOSE
//  Phase sequencer for one SISO decoder half-iteration: LOAD -> ALPHA -> BETA -> LLR.
//  Accepts the input stream and generates branch-block write addresses.
//  Generates alpha/beta RAM write strobes and addresses, and LLR output framing.
//  Sits between the decoder top-level and the branch blocks / alpha RAM / beta RAM.
//  Issues control only; carries no metric data.
// PARAMETERS
//  DWIDTH      16    width of blklen and stream data
//  BLKLEN_MAX  6144  max block length in input words; K = blklen/2 trellis steps
//  NSTATES     8     trellis states per step (power of 2); S = log2(NSTATES)
//  derived: BAW = $clog2(BLKLEN_MAX/2), MAW = $clog2(NSTATES*BLKLEN_MAX/2)
// PORTS
//  aclk         in   1       clock
//  aresetn      in   1       async active-low reset
//  blklen       in   DWIDTH  block length, sampled on accepted start
//  start        in   1       request a run; accepted only in IDLE
//  busy         out  1       high from LOAD through LLR
//  done         out  1       1-cycle pulse when run completes
//  cfg_err      out  1       1-cycle pulse when start is rejected
//  in_valid     in   1       input word valid
//  in_ready     out  1       high only in LOAD
//  br_wrvalid   out  1       branch-block write strobe (= in_valid & in_ready)
//  br_wrsel     out  1       0 = sys word, 1 = parity word (beat[0])
//  br_wraddr    out  BAW     beat >> 1
//  br_rdaddr    out  BAW     current step k in ALPHA/BETA/LLR
//  alpha_wren   out  1       alpha RAM write strobe
//  beta_wren    out  1       beta RAM write strobe
//  metric_addr  out  MAW     {k, s}; shared alpha/beta address
//  llr_valid    out  1       LLR step strobe
//  llr_k        out  BAW     LLR step index
//  llr_tuser    out  1       high with llr_valid at k = 0
//  llr_tlast    out  1       high with llr_valid at k = K-1
// BEHAVIOUR
//  Outputs are registered. Reset value: 0 for all outputs and counters; FSM = IDLE.
//  aresetn low at any time aborts the run immediately; no done pulse.
//  FSM: IDLE, LOAD, ALPHA, BETA, LLR, DONE.
//  IDLE: start with blklen even, nonzero and <= BLKLEN_MAX latches K = blklen/2 -> LOAD.
//    Otherwise cfg_err pulses the next cycle and the FSM stays in IDLE.
//  LOAD: in_ready = 1. Each in_valid beat writes one word (beat 0..blklen-1).
//    in_valid gaps stall the counter.
//    Last beat -> ALPHA next cycle, with in_ready low in that cycle.
//  ALPHA: one write per cycle, s = 0..NSTATES-1 inner loop, k = 0..K-1 outer loop.
//    Duration is K*NSTATES cycles. After (K-1, NSTATES-1) -> BETA.
//  BETA: same pattern with k descending K-1..0 and s ascending.
//    After (0, NSTATES-1) -> LLR.
//  LLR: llr_valid for K consecutive cycles, k = 0..K-1. No backpressure.
//    Then -> DONE.
//  DONE: done = 1 for one cycle, busy = 0, -> IDLE.
//    start in the DONE cycle is ignored; it must be reasserted in IDLE.
//  start while busy is ignored and raises no cfg_err.
//  blklen changes during a run have no effect.
//  Counter wrap: s wraps NSTATES-1 -> 0 with a k increment/decrement. No other wrap.
//  metric_addr = k*NSTATES + s. Maximum is NSTATES*K - 1 (24575 at defaults).
// CONFIGURATION
//  SISO_PHASE_CTRL_ABORT_EN defined: adds input abort (1 bit).
//    abort high in any busy state -> IDLE next cycle.
//    All strobes drop that cycle; no done pulse; abort in IDLE is ignored.
//  Macro undefined: no abort port; a run only terminates via DONE or reset.
// TESTING
//  1 Reset: all outputs 0, in_ready 0, FSM IDLE.
//  2 blklen=8, start, in_valid held high:
//    8 LOAD beats with br_wraddr 0,0,1,1,2,2,3,3 and br_wrsel 0,1,0,1...
//    32 alpha_wren with metric_addr 0..31; 32 beta_wren with metric_addr 24..31,16..23,8..15,0..7.
//    4 llr_valid with tuser at k=0 and tlast at k=3; done exactly 1 cycle later.
//  3 blklen=7, 0 and 6146 each with start: cfg_err pulse, busy stays 0, no strobes.
//  4 blklen=4 with in_valid toggling 1,0,1,0...: in_ready held, exactly 4 writes, ALPHA entered after 4th.
//  5 blklen=6144: final alpha metric_addr 24575, LLR k 0..3071, tlast at 3071.
//  6 aresetn low mid-BETA: outputs 0 asynchronously; next start runs cleanly.
//    With ABORT_EN: abort mid-ALPHA gives IDLE next cycle and no done.

Source files
------------

// File: rtl/siso_phase_ctrl.sv
// Phase sequencer for one SISO half-iteration: LOAD -> ALPHA -> BETA -> LLR -> DONE.
// Define SISO_PHASE_CTRL_ABORT_EN to add the abort input that returns any busy phase to IDLE.
module siso_phase_ctrl #(
  parameter int DWIDTH     = 16,
  parameter int BLKLEN_MAX = 6144,
  parameter int NSTATES    = 8,
  localparam int BAW = $clog2(BLKLEN_MAX/2),
  localparam int MAW = $clog2(NSTATES*BLKLEN_MAX/2)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DWIDTH-1:0] blklen,
  input  logic              start,
`ifdef SISO_PHASE_CTRL_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              br_wrvalid,
  output logic              br_wrsel,
  output logic [BAW-1:0]    br_wraddr,
  output logic [BAW-1:0]    br_rdaddr,
  output logic              alpha_wren,
  output logic              beta_wren,
  output logic [MAW-1:0]    metric_addr,
  output logic              llr_valid,
  output logic [BAW-1:0]    llr_k,
  output logic              llr_tuser,
  output logic              llr_tlast
);
  localparam int S     = $clog2(NSTATES);
  localparam int BEATW = BAW + 1;
  localparam logic [DWIDTH-1:0] MAX_LEN = DWIDTH'(BLKLEN_MAX);
  localparam logic [S-1:0]      S_LAST  = S'(NSTATES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, ALPHA, BETA, LLR, DONE} state_t;

  state_t           state_reg;
  logic [BEATW-1:0] beat_reg;
  logic [BEATW-1:0] last_beat_reg;
  logic [BAW-1:0]   k_reg;
  logic [BAW-1:0]   k_last_reg;
  logic [S-1:0]     s_reg;
  logic             len_ok;

  assign len_ok = !blklen[0] && (blklen != '0) && (blklen <= MAX_LEN);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg     <= IDLE;
      beat_reg      <= '0;
      last_beat_reg <= '0;
      k_reg         <= '0;
      k_last_reg    <= '0;
      s_reg         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cfg_err       <= 1'b0;
      in_ready      <= 1'b0;
      br_wrvalid    <= 1'b0;
      br_wrsel      <= 1'b0;
      br_wraddr     <= '0;
      br_rdaddr     <= '0;
      alpha_wren    <= 1'b0;
      beta_wren     <= 1'b0;
      metric_addr   <= '0;
      llr_valid     <= 1'b0;
      llr_k         <= '0;
      llr_tuser     <= 1'b0;
      llr_tlast     <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted by the active phase below.
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      br_wrvalid <= 1'b0;
      alpha_wren <= 1'b0;
      beta_wren  <= 1'b0;
      llr_valid  <= 1'b0;
      llr_tuser  <= 1'b0;
      llr_tlast  <= 1'b0;
`ifdef SISO_PHASE_CTRL_ABORT_EN
      if (abort && (state_reg inside {LOAD, ALPHA, BETA, LLR})) begin
        state_reg <= IDLE;
        busy      <= 1'b0;
        in_ready  <= 1'b0;
      end else begin
`else
      begin
`endif
        case (state_reg)
          IDLE: begin
            if (start) begin
              if (len_ok) begin
                state_reg     <= LOAD;
                busy          <= 1'b1;
                in_ready      <= 1'b1;
                beat_reg      <= '0;
                last_beat_reg <= BEATW'(blklen - 1'b1);
                k_last_reg    <= BAW'((blklen >> 1) - 1'b1);
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          LOAD: begin
            // in_ready is high for exactly the LOAD state, so in_valid alone is the handshake.
            if (in_valid) begin
              br_wrvalid <= 1'b1;
              br_wrsel   <= beat_reg[0];
              br_wraddr  <= beat_reg[BEATW-1:1];
              if (beat_reg == last_beat_reg) begin
                state_reg <= ALPHA;
                in_ready  <= 1'b0;
                k_reg     <= '0;
                s_reg     <= '0;
              end else begin
                beat_reg <= beat_reg + 1'b1;
              end
            end
          end
          ALPHA: begin
            alpha_wren  <= 1'b1;
            metric_addr <= {k_reg, s_reg};
            br_rdaddr   <= k_reg;
            s_reg       <= s_reg + 1'b1;
            if (s_reg == S_LAST) begin
              if (k_reg == k_last_reg) begin
                state_reg <= BETA;
              end else begin
                k_reg <= k_reg + 1'b1;
              end
            end
          end
          BETA: begin
            beta_wren   <= 1'b1;
            metric_addr <= {k_reg, s_reg};
            br_rdaddr   <= k_reg;
            s_reg       <= s_reg + 1'b1;
            if (s_reg == S_LAST) begin
              if (k_reg == '0) begin
                state_reg <= LLR;
              end else begin
                k_reg <= k_reg - 1'b1;
              end
            end
          end
          LLR: begin
            llr_valid <= 1'b1;
            llr_k     <= k_reg;
            llr_tuser <= (k_reg == '0);
            llr_tlast <= (k_reg == k_last_reg);
            br_rdaddr <= k_reg;
            if (k_reg == k_last_reg) begin
              state_reg <= DONE;
            end else begin
              k_reg <= k_reg + 1'b1;
            end
          end
          DONE: begin
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_siso_phase_ctrl.sv
// Scoreboard bench for siso_phase_ctrl: expected strobes are queued at start and popped as the DUT emits them.
module tb_siso_phase_ctrl;
  localparam int BAW = 12;
  localparam int MAW = 15;
  localparam int NS  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           aresetn;
  logic [15:0]    blklen;
  logic           start;
  logic           in_valid;
`ifdef SISO_PHASE_CTRL_ABORT_EN
  logic           abort;
`endif
  logic           busy, done, cfg_err, in_ready;
  logic           br_wrvalid, br_wrsel;
  logic [BAW-1:0] br_wraddr, br_rdaddr;
  logic           alpha_wren, beta_wren;
  logic [MAW-1:0] metric_addr;
  logic           llr_valid;
  logic [BAW-1:0] llr_k;
  logic           llr_tuser, llr_tlast;

  siso_phase_ctrl dut (
    .aclk(clk), .aresetn(aresetn), .blklen(blklen), .start(start),
`ifdef SISO_PHASE_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready),
    .br_wrvalid(br_wrvalid), .br_wrsel(br_wrsel), .br_wraddr(br_wraddr), .br_rdaddr(br_rdaddr),
    .alpha_wren(alpha_wren), .beta_wren(beta_wren), .metric_addr(metric_addr),
    .llr_valid(llr_valid), .llr_k(llr_k), .llr_tuser(llr_tuser), .llr_tlast(llr_tlast)
  );

  int checks = 0;
  int errors = 0;
  int br_q[$], alpha_q[$], beta_q[$], llr_q[$];
  int cyc = 0, last_br_cyc = 0, last_llr_cyc = 0;
  int done_cnt = 0, cfg_cnt = 0, last_alpha_addr = 0, last_llr_k = 0;
  bit first_alpha = 1'b0, beta_seen = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({busy, done, cfg_err, in_ready, br_wrvalid, br_wrsel, br_wraddr, br_rdaddr,
                alpha_wren, beta_wren, metric_addr, llr_valid, llr_k, llr_tuser, llr_tlast});
  endfunction

  // Monitor: every strobe must match the head of its queue.
  always @(negedge clk) begin
    cyc++;
    if (aresetn) begin
      if (br_wrvalid) begin
        check("br_q_nonempty", 64'(br_q.size() != 0), 64'(1));
        if (br_q.size() != 0) check("br_write", 64'({br_wrsel, br_wraddr}), 64'(br_q.pop_front()));
        last_br_cyc = cyc;
      end
      if (alpha_wren) begin
        check("alpha_q_nonempty", 64'(alpha_q.size() != 0), 64'(1));
        if (alpha_q.size() != 0) check("alpha_addr", 64'(metric_addr), 64'(alpha_q.pop_front()));
        if (first_alpha) begin
          check("alpha_start", 64'(cyc), 64'(last_br_cyc + 1));
          first_alpha = 1'b0;
        end
        last_alpha_addr = int'(metric_addr);
      end
      if (beta_wren) begin
        check("beta_q_nonempty", 64'(beta_q.size() != 0), 64'(1));
        if (beta_q.size() != 0) check("beta_addr", 64'(metric_addr), 64'(beta_q.pop_front()));
        beta_seen = 1'b1;
      end
      if (llr_valid) begin
        check("llr_q_nonempty", 64'(llr_q.size() != 0), 64'(1));
        if (llr_q.size() != 0) check("llr_beat", 64'({llr_k, llr_tuser, llr_tlast}), 64'(llr_q.pop_front()));
        last_llr_cyc = cyc;
        last_llr_k = int'(llr_k);
      end
      if (done) begin
        check("done_latency", 64'(cyc), 64'(last_llr_cyc + 1));
        done_cnt++;
      end
      if (cfg_err) cfg_cnt++;
    end
  end

  task automatic load_expect(input int len);
    int kk = len / 2;
    for (int b = 0; b < len; b++) br_q.push_back(((b % 2) << BAW) + b / 2);
    for (int k = 0; k < kk; k++)
      for (int s = 0; s < NS; s++) alpha_q.push_back(k * NS + s);
    for (int k = kk - 1; k >= 0; k--)
      for (int s = 0; s < NS; s++) beta_q.push_back(k * NS + s);
    for (int k = 0; k < kk; k++)
      llr_q.push_back(k * 4 + ((k == 0) ? 2 : 0) + ((k == kk - 1) ? 1 : 0));
    first_alpha = 1'b1;
  endtask

  task automatic flush_queues();
    br_q.delete(); alpha_q.delete(); beta_q.delete(); llr_q.delete();
  endtask

  task automatic pulse_start(input int len);
    @(posedge clk); #1;
    blklen = 16'(len);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int len, input bit toggle);
    int sent = 0;
    int n = 0;
    in_valid = 1'b0;
    while (sent < len && n < 4 * len + 10) begin
      in_valid = toggle ? ~in_valid : 1'b1;
      @(negedge clk);
      if (toggle && !in_valid && sent > 0) check("in_ready_held", 64'(in_ready), 64'(1));
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check("beats_sent", 64'(sent), 64'(len));
    @(negedge clk);
    check("in_ready_after_load", 64'(in_ready), 64'(0));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 64'(done), 64'(1));
    check("busy_at_done", 64'(busy), 64'(0));
    check("queues_drained", 64'(br_q.size() + alpha_q.size() + beta_q.size() + llr_q.size()), 64'(0));
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'(0));
  endtask

  int bad_lens[3] = '{7, 0, 6146};

  initial begin
    aresetn = 1'b0; blklen = '0; start = 1'b0; in_valid = 1'b0;
`ifdef SISO_PHASE_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    #23;
    check("reset_outputs", outs(), 64'(0));
    @(posedge clk); #1 aresetn = 1'b1;
    @(negedge clk);
    check("idle_outputs", outs(), 64'(0));

    // Nominal run; blklen changed mid-run must not matter.
    $display("run blklen=8 in_valid held");
    load_expect(8);
    pulse_start(8);
    blklen = 16'd2;
    check("busy_after_start", 64'(busy), 64'(1));
    feed(8, 1'b0);
    wait_done(200);
    check("done_cnt_1", 64'(done_cnt), 64'(1));

    // Rejected lengths.
    foreach (bad_lens[i]) begin
      $display("start blklen=%0d (reject)", bad_lens[i]);
      pulse_start(bad_lens[i]);
      @(negedge clk);
      check("cfg_err_pulse", 64'(cfg_err), 64'(1));
      check("cfg_err_busy", 64'(busy), 64'(0));
      @(negedge clk);
      check("cfg_err_clears", 64'({cfg_err, busy, in_ready}), 64'(0));
    end
    check("cfg_cnt", 64'(cfg_cnt), 64'(3));

    // Gapped input; start during the run is ignored without cfg_err.
    $display("run blklen=4 in_valid toggling");
    load_expect(4);
    pulse_start(4);
    feed(4, 1'b1);
    pulse_start(7);
    wait_done(200);
    check("cfg_cnt_busy", 64'(cfg_cnt), 64'(3));
    check("done_cnt_2", 64'(done_cnt), 64'(2));

    // Maximum block.
    $display("run blklen=6144");
    load_expect(6144);
    pulse_start(6144);
    feed(6144, 1'b0);
    wait_done(60000);
    check("max_alpha_addr", 64'(last_alpha_addr), 64'(24575));
    check("max_llr_k", 64'(last_llr_k), 64'(3071));
    check("done_cnt_3", 64'(done_cnt), 64'(3));

    // Asynchronous reset during BETA, then a clean run.
    $display("run blklen=8 reset mid-BETA");
    beta_seen = 1'b0;
    load_expect(8);
    pulse_start(8);
    feed(8, 1'b0);
    for (int n = 0; n < 200 && !beta_seen; n++) @(negedge clk);
    check("beta_reached", 64'(beta_seen), 64'(1));
    #2 aresetn = 1'b0;
    #1 check("async_reset", outs(), 64'(0));
    flush_queues();
    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;
    $display("run blklen=8 after reset");
    load_expect(8);
    pulse_start(8);
    feed(8, 1'b0);
    wait_done(200);
    check("done_cnt_4", 64'(done_cnt), 64'(4));

`ifdef SISO_PHASE_CTRL_ABORT_EN
    $display("run blklen=8 abort mid-ALPHA");
    load_expect(8);
    pulse_start(8);
    feed(8, 1'b0);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_strobe", 64'(alpha_wren), 64'(0));
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(done_cnt), 64'(4));
    check("abort_idle", 64'({busy, alpha_wren, beta_wren, llr_valid}), 64'(0));
    flush_queues();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
